// File: rtl/nios_interval_timer_p.sv
// -----------------------------------------------------------------------------
// nios_interval_timer_p
//
// Parametrised interval timer on the Nios II data master (16-bit Avalon-MM
// slave). It provides a down-counter with a software-writable period,
// start/stop control, one-shot or continuous mode, a counter snapshot and a
// level interrupt.
//
// Bus handshake: the slave has no wait states. A write is accepted in every
// cycle where chipselect=1 and write_n=0 and acts at that clock edge.
// readdata is registered from the address mux on every clock, whether or not
// chipselect is high, so read data is valid exactly one cycle after the
// address is presented.
//
// Parameters:
//   COUNTER_WIDTH   counter/period width, 17..32
//   DEFAULT_PERIOD  period and counter reset value (truncated to COUNTER_WIDTH)
//   START_AT_RESET  1: run in continuous mode from reset, 0: stopped
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register word address (0..7)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   16-bit write data
//   readdata    16-bit registered read data
//   irq         level interrupt, TO & ITO
// -----------------------------------------------------------------------------
module nios_interval_timer_p #(
    parameter int          COUNTER_WIDTH  = 32,
    parameter logic [31:0] DEFAULT_PERIOD = 32'h000F423F,
    parameter bit          START_AT_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

    localparam int                     HI_W         = COUNTER_WIDTH - 16;
    localparam logic [COUNTER_WIDTH-1:0] RESET_PERIOD = DEFAULT_PERIOD[COUNTER_WIDTH-1:0];

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;
    localparam logic [2:0] ADDR_SNAPL   = 3'd4;
    localparam logic [2:0] ADDR_SNAPH   = 3'd5;

    logic [COUNTER_WIDTH-1:0] period;
    logic [COUNTER_WIDTH-1:0] counter;
    logic [COUNTER_WIDTH-1:0] snap;
    logic                     run;
    logic                     cont;
    logic                     ito;
    logic                     to;
    logic                     force_reload;
    logic                     counter_was_nz;

    logic                     wr_en;
    logic                     wr_status;
    logic                     wr_control;
    logic                     wr_period;
    logic                     wr_snap;
    logic                     counter_zero;
    logic                     timeout_evt;
    logic                     run_next;
    logic                     to_next;
    logic [COUNTER_WIDTH-1:0] counter_next;
    logic [31:0]              period_ext;
    logic [31:0]              snap_ext;
    logic [15:0]              rd_mux;

    assign wr_en      = chipselect & ~write_n;
    assign wr_status  = wr_en && (address == ADDR_STATUS);
    assign wr_control = wr_en && (address == ADDR_CONTROL);
    assign wr_period  = wr_en && ((address == ADDR_PERIODL) || (address == ADDR_PERIODH));
    assign wr_snap    = wr_en && ((address == ADDR_SNAPL) || (address == ADDR_SNAPH));

    // A timeout is the transition into zero, so a zero period in continuous
    // mode raises only one event until the counter leaves zero again.
    assign counter_zero = (counter == '0);
    assign timeout_evt  = counter_zero & counter_was_nz;

    assign irq = to & ito;

    // Zero-extended views so the high halves read as 0 above COUNTER_WIDTH.
    assign period_ext = 32'(period);
    assign snap_ext   = 32'(snap);

    always_comb begin
        run_next = run;
        // A period write stops the timer; STOP beats START; START beats a
        // one-shot expiry in the same cycle.
        if (wr_period) begin
            run_next = 1'b0;
        end else if (wr_control && writedata[3]) begin
            run_next = 1'b0;
        end else if (wr_control && writedata[2]) begin
            run_next = 1'b1;
        end else if (run && counter_zero && !cont) begin
            run_next = 1'b0;
        end
    end

    always_comb begin
        counter_next = counter;
        if (force_reload) begin
            counter_next = period;
        end else if (run) begin
            counter_next = counter_zero ? period : counter - COUNTER_WIDTH'(1);
        end
    end

    // Setting beats clearing when an event lands on a STATUS write.
    always_comb begin
        to_next = to;
        if (timeout_evt) begin
            to_next = 1'b1;
        end else if (wr_status) begin
            to_next = 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_STATUS:  rd_mux = {14'd0, run, to};
            ADDR_CONTROL: rd_mux = {14'd0, cont, ito};
            ADDR_PERIODL: rd_mux = period_ext[15:0];
            ADDR_PERIODH: rd_mux = period_ext[31:16];
            ADDR_SNAPL:   rd_mux = snap_ext[15:0];
            ADDR_SNAPH:   rd_mux = snap_ext[31:16];
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period         <= RESET_PERIOD;
            counter        <= RESET_PERIOD;
            snap           <= '0;
            run            <= START_AT_RESET;
            cont           <= START_AT_RESET;
            ito            <= 1'b0;
            to             <= 1'b0;
            force_reload   <= 1'b0;
            counter_was_nz <= (RESET_PERIOD != '0);
            readdata       <= '0;
        end else begin
            counter        <= counter_next;
            run            <= run_next;
            to             <= to_next;
            counter_was_nz <= ~counter_zero;
            readdata       <= rd_mux;
            // The counter picks up the new period on the edge after the write,
            // once the period register itself holds the written half.
            force_reload   <= wr_period;

            if (wr_control) begin
                ito  <= writedata[0];
                cont <= writedata[1];
            end
            if (wr_en && (address == ADDR_PERIODL)) begin
                period[15:0] <= writedata;
            end
            if (wr_en && (address == ADDR_PERIODH)) begin
                period[COUNTER_WIDTH-1:16] <= writedata[HI_W-1:0];
            end
            if (wr_snap) begin
                snap <= counter;
            end
        end
    end

endmodule

// File: tb/tb_nios_interval_timer_p.sv
// -----------------------------------------------------------------------------
// tb_nios_interval_timer_p
//
// Directed bench for nios_interval_timer_p built with COUNTER_WIDTH=20,
// DEFAULT_PERIOD=9 and START_AT_RESET=1. Inputs are driven at the falling
// edge and outputs sampled at the falling edge, so every rising edge sees
// stable inputs. Expected values are hand-derived cycle by cycle.
// -----------------------------------------------------------------------------
module tb_nios_interval_timer_p;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;
    logic [15:0] rd;

    nios_interval_timer_p #(
        .COUNTER_WIDTH  (20),
        .DEFAULT_PERIOD (32'd9),
        .START_AT_RESET (1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, ending at the following falling edge.
    task automatic tick();
        @(negedge clk);
        edge_cnt++;
    endtask

    // Write sampled at the next rising edge.
    task automatic bus_write(input logic [2:0] addr, input logic [15:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Returns register contents as they stood when the task was called.
    task automatic bus_read(input logic [2:0] addr, output logic [15:0] data);
        address    = addr;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        data       = readdata;
        chipselect = 1'b0;
    endtask

    initial begin
        // Reset
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'd0;
        repeat (3) @(negedge clk);
        check_eq("reset_irq", irq, 0);
        check_eq("reset_readdata", readdata, 0);
        reset_n  = 1'b1;
        edge_cnt = 0;

        // Continuous from reset, period 9: TO sets at edges 10, 20, 30.
        while (edge_cnt < 10) tick();
        check_eq("status_pre_e10", readdata, 16'h0002);
        tick();
        check_eq("status_post_e10", readdata, 16'h0003);
        check_eq("irq_ito_off", irq, 0);
        bus_write(3'd0, 16'h0000);
        while (edge_cnt < 20) tick();
        check_eq("status_pre_e20", readdata, 16'h0002);
        tick();
        check_eq("status_post_e20", readdata, 16'h0003);
        bus_write(3'd0, 16'h0000);
        address = 3'd0;
        while (edge_cnt < 30) tick();
        check_eq("status_pre_e30", readdata, 16'h0002);
        tick();
        check_eq("status_post_e30", readdata, 16'h0003);

        // One-shot with period 4
        bus_write(3'd2, 16'd4);
        bus_write(3'd3, 16'd0);
        bus_write(3'd0, 16'h0000);
        bus_write(3'd1, 16'h0005);
        repeat (4) tick();
        check_eq("oneshot_irq_early", irq, 0);
        tick();
        check_eq("oneshot_irq_set", irq, 1);
        bus_read(3'd0, rd);
        check_eq("oneshot_status", rd, 16'h0001);
        bus_read(3'd1, rd);
        check_eq("oneshot_control", rd, 16'h0001);
        bus_write(3'd4, 16'h0000);
        bus_read(3'd4, rd);
        check_eq("oneshot_hold_snap", rd, 16'd4);

        // Continuous period 4: STATUS write in the exact event cycle
        bus_write(3'd0, 16'h0000);
        check_eq("irq_cleared", irq, 0);
        bus_write(3'd1, 16'h0007);
        repeat (4) tick();
        bus_write(3'd0, 16'h0000);
        check_eq("set_wins_irq", irq, 1);
        bus_read(3'd0, rd);
        check_eq("set_wins_status", rd, 16'h0003);
        bus_write(3'd0, 16'h0000);
        check_eq("clear_irq", irq, 0);
        repeat (2) tick();
        check_eq("cont_irq_before", irq, 0);
        tick();
        check_eq("cont_irq_period", irq, 1);

        // START + STOP together, then START + CONT
        bus_write(3'd1, 16'h000C);
        bus_read(3'd0, rd);
        check_eq("stop_wins_status", rd, 16'h0001);
        check_eq("stop_irq_ito0", irq, 0);
        bus_write(3'd1, 16'h0006);
        bus_read(3'd0, rd);
        check_eq("start_status", rd, 16'h0003);
        bus_read(3'd1, rd);
        check_eq("control_readback", rd, 16'h0002);

        // 20-bit period high half, snapshot at 12345, unused addresses
        bus_write(3'd3, 16'hFFFF);
        bus_read(3'd3, rd);
        check_eq("periodh_mask", rd, 16'h000F);
        bus_write(3'd2, 16'h3039);
        bus_write(3'd3, 16'h0000);
        tick();
        bus_write(3'd4, 16'h0000);
        bus_read(3'd4, rd);
        check_eq("snapl_12345", rd, 16'h3039);
        bus_read(3'd5, rd);
        check_eq("snaph_12345", rd, 16'h0000);
        bus_read(3'd2, rd);
        check_eq("periodl_read", rd, 16'h3039);
        bus_write(3'd6, 16'hFFFF);
        bus_read(3'd6, rd);
        check_eq("addr6_zero", rd, 16'h0000);
        bus_read(3'd7, rd);
        check_eq("addr7_zero", rd, 16'h0000);

        // Reset mid-count with irq high
        bus_write(3'd2, 16'd2);
        bus_write(3'd1, 16'h0007);
        repeat (3) tick();
        check_eq("pre_reset_irq", irq, 1);
        check_eq("pre_reset_readdata", readdata, 16'h0003);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_reset_irq", irq, 0);
        check_eq("async_reset_readdata", readdata, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        bus_write(3'd4, 16'h0000);
        bus_read(3'd4, rd);
        check_eq("restart_default", rd, 16'd9);
        bus_read(3'd0, rd);
        check_eq("restart_status", rd, 16'h0002);

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nios_interval_timer_p.md
# nios_interval_timer_p

Parametrised Avalon-MM interval timer for the Nios II system, the successor to the fixed-period free-running system timer. Adds a software-writable period, start/stop control, one-shot or continuous mode and a counter snapshot, with counter width and reset period set by parameters. It sits on the Nios data master as a 16-bit slave with an interrupt line to the CPU.

## Interface
- COUNTER_WIDTH, 32: counter/period width; legal range 17..32.
- DEFAULT_PERIOD, 32'h000F423F: period register reset value, truncated to COUNTER_WIDTH bits.
- START_AT_RESET, 1: 1 means the counter runs in continuous mode from reset; 0 means it is stopped until START.

- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  word address of the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  16  write data.
- readdata  out  16  registered read data.
- irq  out  1  level interrupt, TO & ITO.

## Operation
- Register map:
  - 0 STATUS: bit0 TO, bit1 RUN (read-only). Any write clears TO.
  - 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START (write-only, reads 0), bit3 STOP (write-only, reads 0). Only ITO and CONT are stored.
  - 2 PERIODL and 3 PERIODH: period[15:0] and period[COUNTER_WIDTH-1:16]. PERIODH bits above COUNTER_WIDTH are ignored on write and read as 0.
  - 4 SNAPL and 5 SNAPH: captured counter value.
  - 6 and 7: read as 0; writes are ignored.
- A write takes effect when chipselect=1 and write_n=0.
- Counter:
  - Counts down by 1 per clk while RUN=1.
  - When the counter is 0 and RUN=1, the next cycle reloads it from period. If CONT=0, RUN clears in the same cycle (one-shot).
  - When RUN=0, the counter holds its value.
- Period write (address 2 or 3):
  - Updates the addressed half.
  - Clears RUN.
  - The next cycle loads the counter from the new period (force_reload).
- START sets RUN; STOP clears RUN. If both are written together, STOP wins. START also wins over a one-shot expiry in the same cycle.
- Timeout event: the counter transitions to 0 (it is 0 now and was non-zero last cycle). The event sets TO.
  - An event in the same cycle as a STATUS write: TO ends at 1 (set wins).
  - TO stays set until software clears it.
- Snapshot: any write to address 4 or 5 copies the current counter into the snapshot register on that clock edge. Reads return the snapshot, never the live counter.
- Reset values:
  - period = DEFAULT_PERIOD, counter = DEFAULT_PERIOD.
  - RUN = START_AT_RESET, CONT = START_AT_RESET.
  - ITO = 0, TO = 0, snapshot = 0.
  - readdata = 0, irq = 0.

## Timing
- Read latency is 1 cycle: readdata is registered from the mux every clk, whether or not chipselect is high.
- Writes to registers take effect at the edge where the strobe is sampled. Status and RUN changes are visible on the following read.
- Continuous mode with period P: a timeout event occurs every P+1 cycles. irq rises 1 cycle after the counter reaches 0.
- irq is combinational from the TO and ITO flops: it drops the cycle after a STATUS write or an ITO=0 write.
- After a period write, the counter equals the new period 1 cycle after the write edge. It starts counting only after START.
- Period 0 in continuous mode: the counter stays at 0. Only one timeout event occurs until the counter leaves 0.
- Reset asserted mid-count returns all state to reset values immediately. Any pending interrupt is dropped.

## Test plan
- Reset with START_AT_RESET=1 and DEFAULT_PERIOD=9: irq stays 0. TO sets at cycles 10, 20, 30 after reset. Reading STATUS returns 16'h0003.
- Write PERIODL=4 and PERIODH=0, then CONTROL=16'h0005 (ITO + START, CONT=0): irq rises 5 cycles after reload. RUN reads 0 and the counter holds at 4.
- Continuous mode with period 4 and ITO=1: issue a STATUS write in the exact cycle of a timeout event. TO remains 1 and irq stays high.
- Write CONTROL=16'h000C (START + STOP together): RUN reads 0. Then write 16'h0006: RUN reads 1 and bits 2 and 3 read back 0.
- With COUNTER_WIDTH=20, write PERIODH=16'hFFFF: PERIODH reads 16'h000F. Snapshot taken at counter 12345 returns SNAPL=16'h3039 and SNAPH=0.
- Assert reset_n low mid-count with irq=1: irq and readdata go to 0 asynchronously. After release, the counter restarts from DEFAULT_PERIOD.
